// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/grant/response bus between the LSU and memory.
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half lane of a read word and sign/zero extends it.
module lsu_load_align
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  input  logic [31:0] word,
  output logic [31:0] res
);
  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{off, 3'b000} +: 8];
  assign h = word[{off[1], 4'b0000} +: 16];

  always_comb begin
    res = '0;
    case (f3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_BU:   res = {24'h0, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_HU:   res = {16'h0, h};
      F3_W:    res = word;
      default: res = '0;
    endcase
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: classifies, issues and completes one data-memory access.
// Optional watchdog enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read_M,
  input  logic            mem_write_M,
  input  logic [2:0]      funct3_M,
  input  logic [XLEN-1:0] addr_M,
  input  logic [XLEN-1:0] wdata_M,
  output logic            stall_M,
  output logic            lsu_done,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_err,
  output logic [1:0]      lsu_err_code,
  mem_stage_lsu_if.master dmem
);
  lsu_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] ld_res;
  logic        access, misaligned;

  assign access = mem_read_M | mem_write_M;
  assign misaligned = (funct3_M[1:0] == 2'b01 && addr_M[0]) ||
                      (funct3_M[1:0] == 2'b10 && addr_M[1:0] != 2'b00);

  lsu_load_align u_align (
    .off  (addr_q[1:0]),
    .f3   (f3_q),
    .word (dmem.rdata),
    .res  (ld_res)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = TIMEOUT_CYCLES[0];
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    we_d    = we_q;
    code_d  = code_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: if (access) begin
        addr_d  = addr_M;
        f3_d    = funct3_M;
        we_d    = mem_write_M;
        rdata_d = '0;
        case (funct3_M[1:0])
          2'b00:   begin be_d = 4'b0001 << addr_M[1:0];         wdata_d = {4{wdata_M[7:0]}};  end
          2'b01:   begin be_d = 4'b0011 << {addr_M[1], 1'b0};   wdata_d = {2{wdata_M[15:0]}}; end
          default: begin be_d = 4'hF;                           wdata_d = wdata_M;            end
        endcase
        if ((mem_read_M && mem_write_M) || f3_illegal(funct3_M)) begin
          code_d  = ERR_ILLEGAL;
          state_d = S_DONE;
        end else if (misaligned) begin
          code_d  = ERR_MISALIGN;
          state_d = S_DONE;
        end else begin
          code_d  = ERR_NONE;
          state_d = S_REQ;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_REQ: begin
        if (dmem.gnt) begin
          if (we_q) state_d = S_DONE;
          else if (dmem.rvalid) begin
            rdata_d = ld_res;
            state_d = S_DONE;
          end else state_d = S_RESP;
        end
      end
      S_RESP: if (dmem.rvalid) begin
        rdata_d = ld_res;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef LSU_TIMEOUT_EN
    // A completion in the same cycle wins over the watchdog.
    if ((state_q == S_REQ || state_q == S_RESP) && state_d != S_DONE) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        code_d  = ERR_TIMEOUT;
        rdata_d = '0;
        state_d = S_DONE;
      end else cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      code_q  <= ERR_NONE;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      code_q  <= code_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign stall_M      = (state_q == S_IDLE && access) || state_q == S_REQ || state_q == S_RESP;
  assign lsu_done     = (state_q == S_DONE);
  assign lsu_rdata    = lsu_done ? rdata_q : '0;
  assign lsu_err      = lsu_done && code_q != ERR_NONE;
  assign lsu_err_code = lsu_done ? code_q : ERR_NONE;

  // Bus fields are only driven while the request is outstanding.
  assign dmem.req   = (state_q == S_REQ);
  assign dmem.we    = dmem.req && we_q;
  assign dmem.be    = dmem.req ? be_q : 4'h0;
  assign dmem.addr  = dmem.req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem.wdata = dmem.req ? wdata_q : 32'h0;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed and randomized bench for mem_stage_lsu against an arithmetic reference model.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst_n, mem_read_M, mem_write_M;
  logic [2:0]  funct3_M;
  logic [31:0] addr_M, wdata_M;
  logic        stall_M, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_err_code;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage_lsu_if dmem ();

  mem_stage_lsu #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read_M(mem_read_M), .mem_write_M(mem_write_M),
    .funct3_M(funct3_M), .addr_M(addr_M), .wdata_M(wdata_M), .stall_M(stall_M),
    .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .lsu_err_code(lsu_err_code), .dmem(dmem)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: what the access should produce, from the ISA rules.
  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdw,
                                output logic [1:0] code, output logic [3:0] be,
                                output logic [31:0] wexp, output logic [31:0] res);
    int size, off, v;
    logic [31:0] s;
    size = int'(f3) % 4;
    off  = int'(a[1:0]);
    code = 2'd0;
    if ((rd && wr) || f3 == 3'd3 || f3 >= 3'd6) code = 2'd2;
    else if ((size == 1 && off % 2 != 0) || (size == 2 && off != 0)) code = 2'd1;
    case (size)
      0:       begin be = 4'(1 << off);           wexp = {4{wd[7:0]}};  end
      1:       begin be = 4'(3 << ((off / 2) * 2)); wexp = {2{wd[15:0]}}; end
      default: begin be = 4'hF;                   wexp = wd;            end
    endcase
    res = 32'h0;
    if (!wr && code == 2'd0) begin
      s = rdw >> (8 * off);
      case (f3)
        3'd0, 3'd4: begin v = int'(s & 32'hFF);   if (f3 == 3'd0 && v >= 128)   v -= 256;   res = 32'(v); end
        3'd1, 3'd5: begin v = int'(s & 32'hFFFF); if (f3 == 3'd1 && v >= 32768) v -= 65536; res = 32'(v); end
        default: res = rdw;
      endcase
    end
  endfunction

  // Entered and left at posedge+1; memory grants after gdly request cycles and
  // returns data rdly cycles after the grant.
  task automatic do_access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdw,
                           input int gdly, input int rdly, input bit never_gnt);
    logic [1:0] code, got_code;
    logic [3:0] be;
    logic [31:0] wexp, res, got_rdata;
    logic got_err;
    int stalls, dones, reqs, bad, since, exp_stalls, exp_reqs;
    bit granted, rv_given;
    model(rd, wr, f3, a, wd, rdw, code, be, wexp, res);
    if (code != 2'd0) begin exp_stalls = 1; exp_reqs = 0; end
    else if (never_gnt) begin exp_stalls = 9; exp_reqs = 8; code = 2'd3; res = 32'h0; end
    else begin exp_reqs = gdly + 1; exp_stalls = 1 + exp_reqs + (wr ? 0 : rdly); end
    stalls = 0; dones = 0; reqs = 0; bad = 0; since = 0; granted = 0; rv_given = 0;
    got_err = 0; got_code = 0; got_rdata = 0;
    mem_read_M = rd; mem_write_M = wr; funct3_M = f3; addr_M = a; wdata_M = wd;
    for (int cyc = 0; cyc < 64 && dones == 0; cyc++) begin
      dmem.gnt = 0; dmem.rvalid = 0; dmem.rdata = $urandom;
      #1;
      if (stall_M) stalls++;
      if (lsu_done) begin dones++; got_err = lsu_err; got_code = lsu_err_code; got_rdata = lsu_rdata; end
      if (granted && !wr && !rv_given) begin
        since++;
        if (since == rdly) begin dmem.rvalid = 1; dmem.rdata = rdw; rv_given = 1; end
      end
      if (dmem.req) begin
        reqs++;
        if (dmem.be !== be || dmem.addr !== {a[31:2], 2'b00} || dmem.we !== wr || dmem.wdata !== wexp) bad++;
        if (!granted && !never_gnt && reqs == gdly + 1) begin
          dmem.gnt = 1; granted = 1;
          if (!wr && rdly == 0) begin dmem.rvalid = 1; dmem.rdata = rdw; rv_given = 1; end
        end
      end
      @(posedge clk); #1;
    end
    mem_read_M = 0; mem_write_M = 0; dmem.gnt = 0; dmem.rvalid = 0;
    #1;
    check({nm, ".done_once"}, 32'(dones == 1 && !lsu_done), 32'd1);
    check({nm, ".err"},       32'(got_err), 32'(code != 2'd0));
    check({nm, ".code"},      32'(got_code), 32'(code));
    check({nm, ".rdata"},     got_rdata, res);
    check({nm, ".stalls"},    32'(stalls), 32'(exp_stalls));
    check({nm, ".reqs"},      32'(reqs), 32'(exp_reqs));
    check({nm, ".bus"},       32'(bad), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int r, gd, rd_d;
    rst_n = 0; mem_read_M = 0; mem_write_M = 0; funct3_M = 0; addr_M = 0; wdata_M = 0;
    dmem.gnt = 0; dmem.rvalid = 0; dmem.rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.stall", 32'(stall_M), 32'd0);
    check("rst.done",  32'(lsu_done), 32'd0);
    check("rst.req",   32'(dmem.req), 32'd0);
    check("rst.err",   {30'd0, lsu_err_code} | 32'(lsu_err), 32'd0);
    check("rst.rdata", lsu_rdata, 32'd0);
    check("rst.be",    32'(dmem.be), 32'd0);
    rst_n = 1;
    @(posedge clk); #1;

    do_access("lw100",  1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 0);
    do_access("lb103",  1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 0);
    do_access("lbu103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 0);
    do_access("sh102",  0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 0, 0);
    do_access("lw101",  1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 0);
    do_access("f3_011", 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 0);
    do_access("rdwr",   1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0, 0);
    do_access("gnt5",   1, 0, 3'b001, 32'h206, 32'h0, 32'h7FFF1234, 5, 0, 0);

    // Stale responses while idle must not complete anything.
    dmem.rvalid = 1; dmem.rdata = 32'hA5A5A5A5;
    #1;
    check("stale.idle", 32'(lsu_done | stall_M), 32'd0);
    @(posedge clk); #1;
    check("stale.next", 32'(lsu_done | stall_M), 32'd0);
    dmem.rvalid = 0;

    // Reset while waiting in RESP.
    mem_read_M = 1; funct3_M = 3'b010; addr_M = 32'h300;
    @(posedge clk); #1;
    dmem.gnt = 1;
    @(posedge clk); #1;
    dmem.gnt = 0;
    check("rstresp.in_resp", 32'(stall_M && !dmem.req), 32'd1);
    rst_n = 0; mem_read_M = 0;
    @(posedge clk); #1;
    check("rstresp.idle", 32'(stall_M | dmem.req | lsu_done), 32'd0);
    rst_n = 1; dmem.rvalid = 1;
    r = 0;
    repeat (3) begin @(posedge clk); #1; if (lsu_done) r++; end
    dmem.rvalid = 0;
    check("rstresp.no_done", 32'(r), 32'd0);

`ifdef LSU_TIMEOUT_EN
    do_access("timeout", 1, 0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 0, 1);
    do_access("after_to", 1, 0, 3'b010, 32'h404, 32'h0, 32'h13579BDF, 1, 2, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 7));
      gd = int'($urandom_range(0, 3));
      rd_d = int'($urandom_range(0, 3));
      do_access($sformatf("rnd%0d", i), r < 4, r == 0 || r >= 4, 3'($urandom_range(0, 7)),
                $urandom, $urandom, $urandom, gd, rd_d, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
